// File: rtl/eth_rx_stat.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_stat
// Description : Per-channel Ethernet RX frame statistics with sticky error
//               flag, snapshot shadow registers and registered readout.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_stat #(
    parameter int CH_COUNT = 2,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH_COUNT-1:0] rx_valid,
    input  logic [CH_COUNT-1:0] rx_sof,
    input  logic [CH_COUNT-1:0] rx_eof,
    input  logic [CH_COUNT-1:0] rx_fr_good,
    input  logic [CH_COUNT-1:0] rx_fr_err,
    input  logic                clr,
    input  logic                snap,
    input  logic [1:0]          rd_ch,
    output logic [CNT_W-1:0]    rd_good_cnt,
    output logic [CNT_W-1:0]    rd_bad_cnt,
    output logic [CNT_W-1:0]    rd_seq_cnt,
    output logic [CNT_W-1:0]    rd_byte_cnt,
    output logic [CH_COUNT-1:0] err_pulse,
    output logic                err_det
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    state_t             state_q     [CH_COUNT];
    state_t             state_d     [CH_COUNT];
    logic [CNT_W-1:0]   good_q      [CH_COUNT];
    logic [CNT_W-1:0]   good_d      [CH_COUNT];
    logic [CNT_W-1:0]   bad_q       [CH_COUNT];
    logic [CNT_W-1:0]   bad_d       [CH_COUNT];
    logic [CNT_W-1:0]   seq_q       [CH_COUNT];
    logic [CNT_W-1:0]   seq_d       [CH_COUNT];
    logic [CNT_W-1:0]   byte_q      [CH_COUNT];
    logic [CNT_W-1:0]   byte_d      [CH_COUNT];
    logic [CNT_W-1:0]   sh_good_q   [CH_COUNT];
    logic [CNT_W-1:0]   sh_good_d   [CH_COUNT];
    logic [CNT_W-1:0]   sh_bad_q    [CH_COUNT];
    logic [CNT_W-1:0]   sh_bad_d    [CH_COUNT];
    logic [CNT_W-1:0]   sh_seq_q    [CH_COUNT];
    logic [CNT_W-1:0]   sh_seq_d    [CH_COUNT];
    logic [CNT_W-1:0]   sh_byte_q   [CH_COUNT];
    logic [CNT_W-1:0]   sh_byte_d   [CH_COUNT];
    logic [CNT_W-1:0]   rd_good_q, rd_good_d;
    logic [CNT_W-1:0]   rd_bad_q,  rd_bad_d;
    logic [CNT_W-1:0]   rd_seq_q,  rd_seq_d;
    logic [CNT_W-1:0]   rd_byte_q, rd_byte_d;
    logic [CH_COUNT-1:0] err_pulse_q, err_pulse_d;
    logic               err_det_q, err_det_d;

    logic [CH_COUNT-1:0] w_sof, w_eof, w_cls, w_seq, w_good, w_err;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic inc);
        return (inc && (cnt != c_cnt_max)) ? cnt + CNT_W'(1) : cnt;
    endfunction

    // Event decode: a frame is classified at any qualified eof, except an eof
    // arriving in IDLE without sof, which is a sequence error instead.
    always_comb begin
        w_sof = rx_valid & rx_sof;
        w_eof = rx_valid & rx_eof;
        w_cls = '0;
        w_seq = '0;
        for (int c = 0; c < CH_COUNT; c++) begin
            if (state_q[c] == ST_IDLE) begin
                w_cls[c] = w_eof[c] & w_sof[c];
                w_seq[c] = w_eof[c] & ~w_sof[c];
            end else begin
                w_cls[c] = w_eof[c];
                w_seq[c] = w_sof[c];
            end
        end
        w_good = w_cls & rx_fr_good & ~rx_fr_err;
        w_err  = (w_cls & ~w_good) | rx_fr_err;
    end

    always_comb begin
        err_pulse_d = '0;
        for (int c = 0; c < CH_COUNT; c++) begin
            state_d[c]   = state_q[c];
            good_d[c]    = '0;
            bad_d[c]     = '0;
            seq_d[c]     = '0;
            byte_d[c]    = '0;
            if (!clr) begin
                case (state_q[c])
                    ST_IDLE:  if (w_sof[c] && !w_eof[c]) state_d[c] = ST_FRAME;
                    ST_FRAME: if (w_eof[c])              state_d[c] = ST_IDLE;
                    default:                             state_d[c] = ST_IDLE;
                endcase
                good_d[c]      = sat_inc(good_q[c], w_good[c]);
                bad_d[c]       = sat_inc(bad_q[c],  w_err[c]);
                seq_d[c]       = sat_inc(seq_q[c],  w_seq[c]);
                byte_d[c]      = sat_inc(byte_q[c], rx_valid[c]);
                err_pulse_d[c] = w_err[c] | w_seq[c];
            end else begin
                state_d[c] = ST_IDLE;
            end
            // Shadows take pre-event live values, so snap+clr keeps the old totals
            sh_good_d[c] = snap ? good_q[c] : sh_good_q[c];
            sh_bad_d[c]  = snap ? bad_q[c]  : sh_bad_q[c];
            sh_seq_d[c]  = snap ? seq_q[c]  : sh_seq_q[c];
            sh_byte_d[c] = snap ? byte_q[c] : sh_byte_q[c];
        end
        err_det_d = clr ? 1'b0 : (err_det_q | (|err_pulse_d));
    end

    always_comb begin
        rd_good_d = '0;
        rd_bad_d  = '0;
        rd_seq_d  = '0;
        rd_byte_d = '0;
        for (int c = 0; c < CH_COUNT; c++) begin
            if (int'(rd_ch) == c) begin
                rd_good_d = sh_good_q[c];
                rd_bad_d  = sh_bad_q[c];
                rd_seq_d  = sh_seq_q[c];
                rd_byte_d = sh_byte_q[c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CH_COUNT; c++) begin
                state_q[c]   <= ST_IDLE;
                good_q[c]    <= '0;
                bad_q[c]     <= '0;
                seq_q[c]     <= '0;
                byte_q[c]    <= '0;
                sh_good_q[c] <= '0;
                sh_bad_q[c]  <= '0;
                sh_seq_q[c]  <= '0;
                sh_byte_q[c] <= '0;
            end
            rd_good_q   <= '0;
            rd_bad_q    <= '0;
            rd_seq_q    <= '0;
            rd_byte_q   <= '0;
            err_pulse_q <= '0;
            err_det_q   <= 1'b0;
        end else begin
            for (int c = 0; c < CH_COUNT; c++) begin
                state_q[c]   <= state_d[c];
                good_q[c]    <= good_d[c];
                bad_q[c]     <= bad_d[c];
                seq_q[c]     <= seq_d[c];
                byte_q[c]    <= byte_d[c];
                sh_good_q[c] <= sh_good_d[c];
                sh_bad_q[c]  <= sh_bad_d[c];
                sh_seq_q[c]  <= sh_seq_d[c];
                sh_byte_q[c] <= sh_byte_d[c];
            end
            rd_good_q   <= rd_good_d;
            rd_bad_q    <= rd_bad_d;
            rd_seq_q    <= rd_seq_d;
            rd_byte_q   <= rd_byte_d;
            err_pulse_q <= err_pulse_d;
            err_det_q   <= err_det_d;
        end
    end

    assign rd_good_cnt = rd_good_q;
    assign rd_bad_cnt  = rd_bad_q;
    assign rd_seq_cnt  = rd_seq_q;
    assign rd_byte_cnt = rd_byte_q;
    assign err_pulse   = err_pulse_q;
    assign err_det     = err_det_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_stat.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_rx_stat
// Description : Self-checking bench for eth_rx_stat (32-bit and 8-bit builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_rx_stat;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] rx_valid = '0, rx_sof = '0, rx_eof = '0, rx_fr_good = '0, rx_fr_err = '0;
    logic       clr = 1'b0, snap = 1'b0;
    logic [1:0] rd_ch = '0;

    logic [31:0] g32, b32, s32, y32;
    logic [7:0]  g8, b8, s8, y8;
    logic [1:0]  ep32, ep8;
    logic        ed32, ed8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    eth_rx_stat #(.CH_COUNT(2), .CNT_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
        .rx_fr_good(rx_fr_good), .rx_fr_err(rx_fr_err), .clr(clr), .snap(snap),
        .rd_ch(rd_ch), .rd_good_cnt(g32), .rd_bad_cnt(b32), .rd_seq_cnt(s32),
        .rd_byte_cnt(y32), .err_pulse(ep32), .err_det(ed32));

    eth_rx_stat #(.CH_COUNT(2), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
        .rx_fr_good(rx_fr_good), .rx_fr_err(rx_fr_err), .clr(clr), .snap(snap),
        .rd_ch(rd_ch), .rd_good_cnt(g8), .rd_bad_cnt(b8), .rd_seq_cnt(s8),
        .rd_byte_cnt(y8), .err_pulse(ep8), .err_det(ed8));

    // Reference model: unbounded event totals; saturation applied when compared.
    bit     m_frame [4];
    longint m_good [4], m_bad [4], m_seq [4], m_byte [4];
    longint sh_good[4], sh_bad[4], sh_seq[4], sh_byte[4];
    longint e_good, e_bad, e_seq, e_byte;
    logic [1:0] e_pulse;
    bit     e_det;

    function automatic longint sat(longint x, longint mx);
        return (x > mx) ? mx : x;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_frame[c] = 0;
            m_good[c] = 0; m_bad[c] = 0; m_seq[c] = 0; m_byte[c] = 0;
            sh_good[c] = 0; sh_bad[c] = 0; sh_seq[c] = 0; sh_byte[c] = 0;
        end
        e_good = 0; e_bad = 0; e_seq = 0; e_byte = 0;
        e_pulse = '0; e_det = 0;
    endtask

    // Advance model and DUT by one clock; clr/snap are single-cycle pulses.
    task automatic cycle();
        longint ng, nb, ns, ny;
        int rc;
        bit v, s, e, cls, sq, good, ev;
        rc = int'(rd_ch);
        ng = 0; nb = 0; ns = 0; ny = 0;
        if (rc < 2) begin
            ng = sh_good[rc]; nb = sh_bad[rc]; ns = sh_seq[rc]; ny = sh_byte[rc];
        end
        if (snap) begin
            for (int c = 0; c < 2; c++) begin
                sh_good[c] = m_good[c]; sh_bad[c] = m_bad[c];
                sh_seq[c] = m_seq[c]; sh_byte[c] = m_byte[c];
            end
        end
        e_pulse = '0;
        if (clr) begin
            for (int c = 0; c < 2; c++) begin
                m_frame[c] = 0; m_good[c] = 0; m_bad[c] = 0; m_seq[c] = 0; m_byte[c] = 0;
            end
            e_det = 0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                v = rx_valid[c]; s = v && rx_sof[c]; e = v && rx_eof[c];
                cls = 0; sq = 0;
                if (!m_frame[c]) begin
                    if (s && !e)      m_frame[c] = 1;
                    else if (s && e)  cls = 1;
                    else if (e)       sq = 1;
                end else begin
                    if (e && !s)      begin cls = 1; m_frame[c] = 0; end
                    else if (s && !e) sq = 1;
                    else if (s && e)  begin sq = 1; cls = 1; m_frame[c] = 0; end
                end
                good = cls && rx_fr_good[c] && !rx_fr_err[c];
                ev = (cls && !good) || rx_fr_err[c];
                if (good) m_good[c]++;
                if (ev)   m_bad[c]++;
                if (sq)   m_seq[c]++;
                if (v)    m_byte[c]++;
                e_pulse[c] = ev || sq;
                if (ev || sq) e_det = 1;
            end
        end
        @(posedge clk);
        #1;
        e_good = ng; e_bad = nb; e_seq = ns; e_byte = ny;
        clr = 1'b0;
        snap = 1'b0;
    endtask

    task automatic drive(int c, bit s, bit e, bit g, bit er);
        rx_valid = '0; rx_sof = '0; rx_eof = '0; rx_fr_good = '0; rx_fr_err = '0;
        rx_valid[c] = 1'b1; rx_sof[c] = s; rx_eof[c] = e; rx_fr_good[c] = g; rx_fr_err[c] = er;
        cycle();
    endtask

    task automatic idle(int n);
        rx_valid = '0; rx_sof = '0; rx_eof = '0; rx_fr_good = '0; rx_fr_err = '0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_snap(int ch);
        rd_ch = 2'(ch);
        snap = 1'b1;
        idle(2);
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({g32, b32, s32, y32, ep32, ed32} !== '0) begin
            bad++; $display("FAIL reset_async_32: got %h want 0", {g32, b32, s32, y32, ep32, ed32});
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        idle(2);
        total++;
        if ({g8, b8, s8, y8, ep8, ed8} !== '0) begin
            bad++; $display("FAIL reset_state_8: got %h want 0", {g8, b8, s8, y8, ep8, ed8});
        end
    endtask

    task automatic test_good_frame();
        drive(0, 1, 0, 1, 0);
        for (int i = 0; i < 62; i++) drive(0, 0, 0, 1, 0);
        drive(0, 0, 1, 1, 0);
        do_snap(0);
        total++;
        if ({g32, b32, s32, y32} !== {32'd1, 32'd0, 32'd0, 32'd64}) begin
            bad++; $display("FAIL good_frame_cnt: got %h want 1/0/0/64", {g32, b32, s32, y32});
        end
        total++;
        if (ed32 !== 1'b0) begin
            bad++; $display("FAIL good_frame_det: got %b want 0", ed32);
        end
    endtask

    task automatic test_bad_frame();
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 1, 0, 0);
        total++;
        if ({ep32, ed32} !== 3'b101) begin
            bad++; $display("FAIL bad_frame_pulse: got %b want 101", {ep32, ed32});
        end
        idle(1);
        total++;
        if ({ep32, ed32} !== 3'b001) begin
            bad++; $display("FAIL bad_frame_hold: got %b want 001", {ep32, ed32});
        end
        do_snap(1);
        total++;
        if ({g32, b32, s32, y32} !== {32'd0, 32'd1, 32'd0, 32'd2}) begin
            bad++; $display("FAIL bad_frame_cnt: got %h want 0/1/0/2", {g32, b32, s32, y32});
        end
        clr = 1'b1;
        idle(1);
        total++;
        if ({ed32, g32, b32, s32, y32} !== {1'b0, 32'd0, 32'd1, 32'd0, 32'd2}) begin
            bad++; $display("FAIL clr_keeps_shadow: got %h want det0 0/1/0/2", {ed32, g32, b32, s32, y32});
        end
        do_snap(1);
        total++;
        if ({g32, b32, s32, y32} !== '0) begin
            bad++; $display("FAIL clr_live_zero: got %h want 0", {g32, b32, s32, y32});
        end
    endtask

    task automatic test_seq();
        clr = 1'b1;
        idle(1);
        drive(0, 1, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 1, 0, 1, 0);
        total++;
        if (ep32 !== 2'b01) begin
            bad++; $display("FAIL seq_sof_pulse: got %b want 01", ep32);
        end
        drive(0, 0, 1, 1, 0);
        do_snap(0);
        total++;
        if ({g32, b32, s32, y32} !== {32'd1, 32'd0, 32'd1, 32'd5}) begin
            bad++; $display("FAIL seq_double_sof: got %h want 1/0/1/5", {g32, b32, s32, y32});
        end
        drive(0, 0, 1, 1, 0);
        total++;
        if (ep32 !== 2'b01) begin
            bad++; $display("FAIL seq_eof_pulse: got %b want 01", ep32);
        end
        do_snap(0);
        total++;
        if ({g32, b32, s32, y32} !== {32'd1, 32'd0, 32'd2, 32'd6}) begin
            bad++; $display("FAIL seq_orphan_eof: got %h want 1/0/2/6", {g32, b32, s32, y32});
        end
    endtask

    task automatic test_saturate();
        clr = 1'b1;
        idle(1);
        for (int i = 0; i < 300; i++) drive(0, 1, 1, 1, 0);
        do_snap(0);
        total++;
        if ({g8, b8, s8, y8} !== {8'd255, 8'd0, 8'd0, 8'd255}) begin
            bad++; $display("FAIL sat_w8: got %h want ff/0/0/ff", {g8, b8, s8, y8});
        end
        total++;
        if ({g32, y32} !== {32'd300, 32'd300}) begin
            bad++; $display("FAIL sat_w32: got %h want 300/300", {g32, y32});
        end
    endtask

    task automatic test_clr_collide();
        clr = 1'b1;
        idle(1);
        drive(0, 1, 0, 1, 0);
        clr = 1'b1;
        drive(0, 0, 1, 1, 0);
        do_snap(0);
        total++;
        if ({g32, b32, s32, y32} !== '0) begin
            bad++; $display("FAIL clr_eof_same: got %h want 0", {g32, b32, s32, y32});
        end
        for (int i = 0; i < 7; i++) drive(0, 1, 1, 1, 0);
        rd_ch = 2'd0;
        snap = 1'b1;
        clr = 1'b1;
        idle(2);
        total++;
        if ({g32, b32, s32, y32} !== {32'd7, 32'd0, 32'd0, 32'd7}) begin
            bad++; $display("FAIL snap_clr_same: got %h want 7/0/0/7", {g32, b32, s32, y32});
        end
        do_snap(0);
        total++;
        if (g32 !== 32'd0) begin
            bad++; $display("FAIL snap_clr_live: got %0d want 0", g32);
        end
    endtask

    task automatic test_async_reset();
        drive(1, 1, 1, 0, 0);
        do_snap(1);
        drive(0, 1, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        #2 rst = 1'b1;
        rx_valid = '0; rx_sof = '0; rx_eof = '0; rx_fr_good = '0; rx_fr_err = '0;
        #1;
        total++;
        if ({g32, b32, s32, y32, ep32, ed32, g8, b8, s8, y8, ep8, ed8} !== '0) begin
            bad++; $display("FAIL async_rst: got %h want 0", {g32, b32, s32, y32, ep32, ed32, g8, b8, s8, y8, ep8, ed8});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        drive(0, 0, 1, 1, 0);
        total++;
        if (ep32 !== 2'b01) begin
            bad++; $display("FAIL rst_orphan_pulse: got %b want 01", ep32);
        end
        do_snap(0);
        total++;
        if ({g32, b32, s32, y32} !== {32'd0, 32'd0, 32'd1, 32'd1}) begin
            bad++; $display("FAIL rst_orphan_cnt: got %h want 0/0/1/1", {g32, b32, s32, y32});
        end
        rd_ch = 2'd3;
        idle(2);
        total++;
        if ({g32, b32, s32, y32, g8, b8, s8, y8} !== '0) begin
            bad++; $display("FAIL rd_ch_oob: got %h want 0", {g32, b32, s32, y32, g8, b8, s8, y8});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < 2; c++) begin
                rx_valid[c]   = ($urandom_range(0, 9) < 7);
                rx_sof[c]     = ($urandom_range(0, 7) == 0);
                rx_eof[c]     = ($urandom_range(0, 7) == 0);
                rx_fr_good[c] = ($urandom_range(0, 3) != 0);
                rx_fr_err[c]  = ($urandom_range(0, 15) == 0);
            end
            clr   = ($urandom_range(0, 63) == 0);
            snap  = ($urandom_range(0, 7) == 0);
            rd_ch = 2'($urandom_range(0, 3));
            cycle();
            total++;
            if ({ep32, ed32} !== {e_pulse, e_det}) begin
                bad++; $display("FAIL rand_err32 @%0d: got %b want %b", i, {ep32, ed32}, {e_pulse, e_det});
            end
            total++;
            if ({ep8, ed8} !== {e_pulse, e_det}) begin
                bad++; $display("FAIL rand_err8 @%0d: got %b want %b", i, {ep8, ed8}, {e_pulse, e_det});
            end
            total++;
            if ({g32, b32, s32, y32} !== {32'(e_good), 32'(e_bad), 32'(e_seq), 32'(e_byte)}) begin
                bad++; $display("FAIL rand_rd32 @%0d: got %h want %h", i, {g32, b32, s32, y32},
                                {32'(e_good), 32'(e_bad), 32'(e_seq), 32'(e_byte)});
            end
            total++;
            if ({g8, b8, s8, y8} !== {8'(sat(e_good, 255)), 8'(sat(e_bad, 255)),
                                      8'(sat(e_seq, 255)), 8'(sat(e_byte, 255))}) begin
                bad++; $display("FAIL rand_rd8 @%0d: got %h want %0d/%0d/%0d/%0d", i, {g8, b8, s8, y8},
                                sat(e_good, 255), sat(e_bad, 255), sat(e_seq, 255), sat(e_byte, 255));
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_good_frame();
        test_bad_frame();
        test_seq();
        test_saturate();
        test_clr_collide();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
